// File: rtl/seq_chunk_addsub.sv
// Multi-cycle N-bit adder/subtractor: CHUNK bits per clock, LSB slice first, registered ripple carry.
// Optional: define ADDSUB_SAT_EN to saturate the result on signed overflow.
module seq_chunk_addsub #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int NC = N / CHUNK;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;

    if (CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_chunk_addsub: CHUNK must be >= 1 and divide N");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    a_q, b_q, sum_q;
    logic            carry_q, cout_q, ovf_q, zero_q;
    logic [IW-1:0]   idx_q;

    logic [CHUNK:0]  csum;
    logic [N-1:0]    sum_d, res_d;
    logic [31:0]     lo;
    logic            last, ovf_d;

    always_comb begin
        lo    = {{(32-IW){1'b0}}, idx_q} * CHUNK;
        csum  = {1'b0, a_q[lo +: CHUNK]} + {1'b0, b_q[lo +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
        sum_d = sum_q;
        sum_d[lo +: CHUNK] = csum[CHUNK-1:0];
        last  = (idx_q == IW'(NC - 1));
        // Only meaningful on the final chunk, when every slice of sum_d is fresh.
        ovf_d = (a_q[N-1] == b_q[N-1]) && (sum_d[N-1] != a_q[N-1]);
`ifdef ADDSUB_SAT_EN
        res_d = sum_d;
        if (ovf_d) res_d = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
        res_d = sum_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= sub ? ~b : b;
                    carry_q <= sub ? 1'b1 : cin;
                    idx_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    carry_q <= csum[CHUNK];
                    if (last) begin
                        sum_q   <= res_d;
                        cout_q  <= csum[CHUNK];
                        ovf_q   <= ovf_d;
                        zero_q  <= (res_d == '0);
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        sum_q <= sum_d;
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Directed bench for seq_chunk_addsub: CHUNK=8 instance plus a CHUNK=32 instance for 1-cycle latency.
module tb_seq_chunk_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv0 = 0, ir0, sb0 = 0, ci0 = 0, ov0, or0 = 0, co0, of0, z0;
    logic [31:0] a0 = 0, b0 = 0, s0;
    logic        iv1 = 0, ir1, sb1 = 0, ci1 = 0, ov1, or1 = 0, co1, of1, z1;
    logic [31:0] a1 = 0, b1 = 0, s1;

    seq_chunk_addsub #(.N(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .sub(sb0), .cin(ci0), .out_valid(ov0), .out_ready(or0), .sum(s0),
        .cout(co0), .ovf(of0), .zero(z0));

    seq_chunk_addsub #(.N(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .sub(sb1), .cin(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1),
        .cout(co1), .ovf(of1), .zero(z1));

`ifdef ADDSUB_SAT_EN
    localparam logic [31:0] POS_OVF_SUM = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_OVF_SUM = 32'h8000_0000;
`else
    localparam logic [31:0] POS_OVF_SUM = 32'h8000_0000;
    localparam logic [31:0] NEG_OVF_SUM = 32'h7FFF_FFFF;
`endif

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on instance sel, measure latency, check result, then retire it.
    task automatic run(input int sel, input string tag,
                       input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                       input logic [31:0] esum, input logic ecout, input logic eovf, input logic ezero,
                       input int elat);
        int cyc;
        logic [31:0] s;
        logic v, c, o, z, r;
        r = (sel == 0) ? ir0 : ir1;
        chk({tag, ".in_ready"}, 64'(r), 64'd1);
        if (sel == 0) begin a0 = a; b0 = b; sb0 = sub; ci0 = cin; iv0 = 1; end
        else          begin a1 = a; b1 = b; sb1 = sub; ci1 = cin; iv1 = 1; end
        tick();
        iv0 = 0; iv1 = 0;
        cyc = 0;
        v = 0;
        while (!v && cyc < 20) begin
            tick();
            cyc++;
            v = (sel == 0) ? ov0 : ov1;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(elat));
        s = (sel == 0) ? s0 : s1;
        c = (sel == 0) ? co0 : co1;
        o = (sel == 0) ? of0 : of1;
        z = (sel == 0) ? z0 : z1;
        chk({tag, ".sum"}, 64'(s), 64'(esum));
        chk({tag, ".flags"}, 64'({c, o, z}), 64'({ecout, eovf, ezero}));
        if (sel == 0) or0 = 1; else or1 = 1;
        tick();
        or0 = 0; or1 = 0;
        v = (sel == 0) ? ov0 : ov1;
        r = (sel == 0) ? ir0 : ir1;
        chk({tag, ".retire"}, 64'({v, r}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst.in_ready", 64'({ir0, ir1}), 64'd0);
        chk("rst.outs", 64'({ov0, co0, of0, z0, s0}), 64'd0);
        rst = 0;
        #1;
        chk("rst.release_ready", 64'({ir0, ir1}), 64'b11);

        run(0, "add",      32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0, 0, 4);
        run(0, "wrap",     32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1, 4);
        run(0, "wrap_cin", 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 32'h0000_0001, 1, 0, 0, 4);
        run(0, "ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, POS_OVF_SUM,   0, 1, 0, 4);
        run(0, "sub5_7",   32'd5, 32'd7, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 4);
        run(0, "sub7_5",   32'd7, 32'd5, 1, 0, 32'd2,         1, 0, 0, 4);
        run(0, "sub5_5",   32'd5, 32'd5, 1, 0, 32'd0,         1, 0, 1, 4);
        run(0, "ovf_neg",  32'h8000_0000, 32'd1, 1, 0, NEG_OVF_SUM, 1, 1, 0, 4);
        run(0, "carry_chain", 32'h00FF_FFFF, 32'h0000_0001, 0, 0, 32'h0100_0000, 0, 0, 0, 4);

        // Backpressure: result holds, a new request is ignored while DONE
        a0 = 32'h10; b0 = 32'h20; sb0 = 0; ci0 = 0; iv0 = 1;
        tick();
        iv0 = 0;
        repeat (4) tick();
        chk("bp.valid", 64'(ov0), 64'd1);
        a0 = 32'h1234; b0 = 32'h1; iv0 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp.hold", 64'({ov0, ir0, co0, of0, z0, s0}), 64'({1'b1, 1'b0, 3'b000, 32'h30}));
        end
        iv0 = 0;
        or0 = 1;
        tick();
        or0 = 0;
        chk("bp.retire", 64'({ov0, ir0}), 64'b01);
        tick();
        chk("bp.retained", 64'({ov0, s0}), 64'({1'b0, 32'h30}));

        // Reset two BUSY cycles into an operation
        a0 = 32'hFFFF_FFFF; b0 = 32'h1; iv0 = 1;
        tick();
        iv0 = 0;
        repeat (2) tick();
        rst = 1;
        #1;
        chk("midrst.ready_low", 64'(ir0), 64'd0);
        tick();
        rst = 0;
        #1;
        chk("midrst.outs", 64'({ov0, ir0, co0, of0, z0, s0}), 64'({1'b0, 1'b1, 3'b000, 32'h0}));
        run(0, "post_rst", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0, 4);

        // Single-chunk instance
        run(1, "c32.add", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0, 1);
        run(1, "c32.ovf", 32'h7FFF_FFFF, 32'd1, 0, 0, POS_OVF_SUM, 0, 1, 0, 1);
        a1 = 32'd9; b1 = 32'd9; sb1 = 1; iv1 = 1;
        tick();
        iv1 = 0;
        tick();
        chk("c32.done", 64'({ov1, s1, z1}), 64'({1'b1, 32'd0, 1'b1}));
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("c32.midrst", 64'({ov1, ir1, s1, z1, co1}), 64'({1'b0, 1'b1, 32'd0, 2'b00}));
        run(1, "c32.post_rst", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
